// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// Entry = destination register index plus result data; r15 is the PC.
package wb_pkg;
    localparam int REG_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_PC = 4'hF;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer: DEPTH x wb_entry_t, pointers, count, valid vector.
// Ports: push/push_entry in, pop in, head/count/ents/valids out,
// rd_ptr out only when WB_FWD_EN is defined (needed for age ordering).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [CNT_W-1:0]       count,
    output wb_entry_t [DEPTH-1:0]  ents,
    output logic [DEPTH-1:0]       valids
`ifdef WB_FWD_EN
    ,
    output logic [PTR_W-1:0]       rd_ptr
`endif
);
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            count  <= '0;
            valids <= '0;
            ents   <= '0;
        end else begin
            if (push) begin
                ents[wr_q]   <= push_entry;
                valids[wr_q] <= 1'b1;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) begin
                valids[rd_q] <= 1'b0;
                rd_q         <= rd_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = ents[rd_q];

`ifdef WB_FWD_EN
    assign rd_ptr = rd_q;
`endif
endmodule

// File: rtl/writeback_queue.sv
// Register-file write-port producer: accepts ALU/load results (mem first),
// retires one per cycle as regwBoolean/rwselector/rwdata or pc_we/pc_data,
// and flags pending writes to decode sources (rs1_busy/rs2_busy).
// Optional macro WB_FWD_EN adds rsX_fwd_valid/rsX_fwd_data forwarding ports.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              regwBoolean,
    output logic [REG_W-1:0]  rwselector,
    output logic [DATA_W-1:0] rwdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_data,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic [REG_W-1:0]  dec_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              full,
    output logic              empty
`ifdef WB_FWD_EN
    ,
    output logic              rs1_fwd_valid,
    output logic              rs2_fwd_valid,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic [DATA_W-1:0] rs2_fwd_data
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  push;
    logic                  pop;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic [CNT_W-1:0]      count;
    wb_entry_t [DEPTH-1:0] ents;
    logic [DEPTH-1:0]      valids;
`ifdef WB_FWD_EN
    logic [PTR_W-1:0]      rd_ptr;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .ents       (ents),
        .valids     (valids)
`ifdef WB_FWD_EN
        ,
        .rd_ptr     (rd_ptr)
`endif
    );

    // Ready comes from the registered count only: no full-time bypass.
    assign full      = (count == CNT_W'(DEPTH));
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign push = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign pop  = (count != '0);

    always_comb begin
        push_entry = '{rd: alu_rd, data: alu_data};
        if (mem_valid)
            push_entry = '{rd: mem_rd, data: mem_data};
    end

    assign empty = (count == '0) && !regwBoolean && !pc_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwBoolean <= 1'b0;
            rwselector  <= '0;
            rwdata      <= '0;
            pc_we       <= 1'b0;
            pc_data     <= '0;
        end else if (pop && head.rd == REG_PC) begin
            regwBoolean <= 1'b0;
            pc_we       <= 1'b1;
            pc_data     <= head.data;
        end else if (pop) begin
            regwBoolean <= 1'b1;
            rwselector  <= head.rd;
            rwdata      <= head.data;
            pc_we       <= 1'b0;
        end else begin
            regwBoolean <= 1'b0;
            pc_we       <= 1'b0;
        end
    end

    // r15 reads come from the PC path, so they never wait on the queue.
    always_comb begin
        rs1_busy = regwBoolean && (rwselector == dec_rs1);
        rs2_busy = regwBoolean && (rwselector == dec_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (valids[i] && ents[i].rd == dec_rs1)
                rs1_busy = 1'b1;
            if (valids[i] && ents[i].rd == dec_rs2)
                rs2_busy = 1'b1;
        end
        if (dec_rs1 == REG_PC)
            rs1_busy = 1'b0;
        if (dec_rs2 == REG_PC)
            rs2_busy = 1'b0;
    end

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] idx;

    // Walk head->tail so the youngest match is the last one assigned.
    always_comb begin
        rs1_fwd_data = rwdata;
        rs2_fwd_data = rwdata;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (valids[idx] && ents[idx].rd == dec_rs1)
                rs1_fwd_data = ents[idx].data;
            if (valids[idx] && ents[idx].rd == dec_rs2)
                rs2_fwd_data = ents[idx].data;
        end
    end

    assign rs1_fwd_valid = rs1_busy;
    assign rs2_fwd_valid = rs2_busy;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Directed + randomized bench for writeback_queue.
// Reference model: a result queue plus the last retired write.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_rd;
    logic [31:0] mem_data;
    logic        regwBoolean;
    logic [3:0]  rwselector;
    logic [31:0] rwdata;
    logic        pc_we;
    logic [31:0] pc_data;
    logic [3:0]  dec_rs1, dec_rs2;
    logic        rs1_busy, rs2_busy;
    logic        full, empty;
`ifdef WB_FWD_EN
    logic        rs1_fwd_valid, rs2_fwd_valid;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .regwBoolean (regwBoolean),
        .rwselector  (rwselector),
        .rwdata      (rwdata),
        .pc_we       (pc_we),
        .pc_data     (pc_data),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .full        (full),
        .empty       (empty)
`ifdef WB_FWD_EN
        ,
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_we, m_pcwe;
    logic [3:0]  m_sel;
    logic [31:0] m_data, m_pcdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(logic [3:0] r);
        if (r == 4'hF) return 1'b0;
        if (m_we && m_sel == r) return 1'b1;
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] fwd_of(logic [3:0] r);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == r) return q[i].d;
        return m_data;
    endfunction

    task automatic model_clear();
        q.delete();
        m_we   = 1'b0;
        m_pcwe = 1'b0;
    endtask

    // One cycle: check registered outputs, drive, check comb, clock model.
    task automatic step(logic mv, logic [3:0] mrd, logic [31:0] md,
                        logic av, logic [3:0] ard, logic [31:0] ad,
                        logic [3:0] r1, logic [3:0] r2);
        logic room, acc_m, acc_a;
        ent_t e;
        @(negedge clk);
        chk("we", regwBoolean, m_we);
        chk("pc_we", pc_we, m_pcwe);
        if (m_we) begin
            chk("rwsel", rwselector, m_sel);
            chk("rwdata", rwdata, m_data);
        end
        if (m_pcwe) chk("pc_data", pc_data, m_pcdata);
        chk("empty", empty, q.size() == 0 && !m_we && !m_pcwe);
        chk("full", full, q.size() == DEPTH);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        dec_rs1 = r1; dec_rs2 = r2;
        #1;
        room  = q.size() < DEPTH;
        acc_m = mv && room;
        acc_a = av && !mv && room;
        chk("mem_ready", mem_ready, room);
        chk("alu_ready", alu_ready, room && !mv);
        chk("rs1_busy", rs1_busy, busy_of(r1));
        chk("rs2_busy", rs2_busy, busy_of(r2));
`ifdef WB_FWD_EN
        chk("rs1_fv", rs1_fwd_valid, busy_of(r1));
        chk("rs2_fv", rs2_fwd_valid, busy_of(r2));
        if (busy_of(r1)) chk("rs1_fd", rs1_fwd_data, fwd_of(r1));
        if (busy_of(r2)) chk("rs2_fd", rs2_fwd_data, fwd_of(r2));
`endif
        @(posedge clk);
        m_we = 1'b0;
        m_pcwe = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.rd == 4'hF) begin
                m_pcwe = 1'b1; m_pcdata = e.d;
            end else begin
                m_we = 1'b1; m_sel = e.rd; m_data = e.d;
            end
        end
        if (acc_m) q.push_back('{rd: mrd, d: md});
        else if (acc_a) q.push_back('{rd: ard, d: ad});
    endtask

    task automatic idle(int n, logic [3:0] r1, logic [3:0] r2);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    logic [3:0] rr;

    initial begin
        rst = 1'b1;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        dec_rs1 = 0; dec_rs2 = 0;
        model_clear();
        #1;
        chk("rst_we", regwBoolean, 1'b0);
        chk("rst_pcwe", pc_we, 1'b0);
        chk("rst_sel", rwselector, 4'h0);
        chk("rst_data", rwdata, 32'h0);
        chk("rst_pcdata", pc_data, 32'h0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single ALU result: write enable two edges after accept
        step(0, 0, 0, 1, 4'd3, 32'h1234, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_we", regwBoolean, 1'b1);
        chk("t1_sel", rwselector, 4'd3);
        chk("t1_data", rwdata, 32'h1234);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_we_off", regwBoolean, 1'b0);

        // mem wins over alu, alu lands next cycle
        step(1, 4'd7, 32'hAAAA, 1, 4'd8, 32'hBBBB, 0, 0);
        step(0, 0, 0, 1, 4'd8, 32'hBBBB, 0, 0);
        #1;
        chk("t2_first", rwselector, 4'd7);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t2_second", rwselector, 4'd8);
        idle(2, 0, 0);

        // back-to-back burst of four
        for (int i = 0; i < 4; i++)
            step(1, 4'(i + 1), 32'h100 + i, 0, 0, 0, 4'd2, 4'd4);
        idle(3, 4'd2, 4'd4);

        // r15 goes to the PC path and is never busy
        step(0, 0, 0, 1, 4'hF, 32'h40, 4'hF, 0);
        step(0, 0, 0, 0, 0, 0, 4'hF, 0);
        #1;
        chk("t4_pcwe", pc_we, 1'b1);
        chk("t4_pcdata", pc_data, 32'h40);
        chk("t4_we", regwBoolean, 1'b0);
        chk("t4_busy", rs1_busy, 1'b0);
        idle(2, 4'hF, 0);

        // same rd twice: busy until the younger write retires
        step(0, 0, 0, 1, 4'd5, 32'hA, 0, 4'd5);
        step(0, 0, 0, 1, 4'd5, 32'hB, 0, 4'd5);
        #1;
        chk("t5_busy_a", rs2_busy, 1'b1);
`ifdef WB_FWD_EN
        chk("t5_fwd", rs2_fwd_data, 32'hB);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 4'd5);
        #1;
        chk("t5_busy_b", rs2_busy, 1'b1);
        chk("t5_last", rwdata, 32'hB);
        step(0, 0, 0, 0, 0, 0, 0, 4'd5);
        #1;
        chk("t5_busy_c", rs2_busy, 1'b0);
        idle(1, 0, 0);

        // reset with results pending
        step(1, 4'd9, 32'h9, 0, 0, 0, 0, 0);
        step(1, 4'd10, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 4'd11; mem_data = 32'h11;
        rst = 1'b1;
        #1;
        chk("t6_empty", empty, 1'b1);
        chk("t6_we", regwBoolean, 1'b0);
        model_clear();
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_we_hold", regwBoolean, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(2, 4'd9, 4'd10);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] a, b;
            rr = 4'($urandom_range(0, 3));
            a  = (rr == 0) ? 4'hF : 4'($urandom_range(0, 6));
            rr = 4'($urandom_range(0, 3));
            b  = (rr == 0) ? 4'hF : 4'($urandom_range(0, 6));
            step($urandom_range(0, 2) == 0, a, $urandom,
                 $urandom_range(0, 1) == 1, b, $urandom,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)));
        end
        idle(3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
